// File: rtl/dma_chan_ctrl_pkg.sv
// Shared types and constants for the two-channel DMA request/sequencing stage.
package dma_pkg;

  localparam int unsigned ADDR_W  = 6;
  localparam int unsigned LEN_W   = 6;
  localparam int unsigned MAX_LEN = 32;
  localparam int unsigned OFF_W   = ADDR_W - 1;
  localparam int unsigned NCH     = 2;

  // Request code bit positions: {dir, valid, ch}
  localparam int unsigned DIR = 2;
  localparam int unsigned VLD = 1;
  localparam int unsigned CH  = 0;

  localparam logic DIR_RD = 1'b0;
  localparam logic DIR_WR = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    XFER = 2'd2,
    DONE = 2'd3
  } state_t;

  typedef struct packed {
    logic             dir;
    logic [OFF_W-1:0] start;
    logic [LEN_W-1:0] len;
  } cfg_t;

  // Lengths beyond the channel region are cut to the region size
  function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len);
    return (len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : len;
  endfunction

endpackage

// File: rtl/dma_chan_ctrl_if.sv
// Configuration, hold-handshake and request-code signals of dma_chan_ctrl.
interface dma_chan_ctrl_if;
  import dma_pkg::*;

  logic              cfg_we;
  logic              cfg_ch;
  logic              cfg_dir;
  logic [OFF_W-1:0]  cfg_start;
  logic [LEN_W-1:0]  cfg_len;
  logic              holdack;
  logic              hRDY;
  logic              intrack;
  logic              rhr;
  logic [2:0]        intrREQ;
  logic [ADDR_W-1:0] Addressin;
  logic [NCH-1:0]    busy;
  logic [NCH-1:0]    done;

  modport master (
    input  cfg_we, cfg_ch, cfg_dir, cfg_start, cfg_len,
    input  holdack, hRDY, intrack,
    output rhr, intrREQ, Addressin, busy, done
  );

  modport slave (
    output cfg_we, cfg_ch, cfg_dir, cfg_start, cfg_len,
    output holdack, hRDY, intrack,
    input  rhr, intrREQ, Addressin, busy, done
  );

endinterface

// File: rtl/dma_chan_ctrl_regs.sv
// One channel: latched config, wrapping offset counter, remaining count, busy flag.
module dma_chan_regs
  import dma_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_we,
  input  cfg_t             cfg,
  input  logic             beat,
  input  logic             clear,
  output logic             busy,
  output logic             dir,
  output logic [OFF_W-1:0] offset,
  output logic [LEN_W-1:0] remaining
);

  logic arm;

  // Writes to an armed channel and zero-length writes leave it untouched
  assign arm = cfg_we && !busy && (cfg.len != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy      <= 1'b0;
      dir       <= DIR_RD;
      offset    <= '0;
      remaining <= '0;
    end else if (arm) begin
      busy      <= 1'b1;
      dir       <= cfg.dir;
      offset    <= cfg.start;
      remaining <= clamp_len(cfg.len);
    end else begin
      if (beat) begin
        // Offset wraps inside the region; the channel bit never changes
        offset    <= offset + OFF_W'(1);
        remaining <= remaining - LEN_W'(1);
      end
      if (clear) begin
        busy <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/dma_chan_ctrl.sv
// Two-channel DMA request sequencer: arbitration, hold handshake, per-beat addressing.
// DMA_CHAN_RR_ARB_EN selects round-robin arbitration; default is fixed channel-0 priority.
module dma_chan_ctrl
  import dma_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  dma_chan_ctrl_if.master bus
);

  state_t            state, state_nxt;
  logic              sel, sel_nxt;
  logic              grant;
  logic              accept;
  logic              rhr_nxt;
  logic [2:0]        req_nxt;
  logic [ADDR_W-1:0] addr_nxt;
  logic [NCH-1:0]    done_nxt;
  logic [NCH-1:0]    ch_busy, ch_dir, ch_beat, ch_clear;
  logic [OFF_W-1:0]  ch_off [NCH];
  logic [LEN_W-1:0]  ch_rem [NCH];
  logic [OFF_W-1:0]  cur_off;
  cfg_t              cfg;

  assign cfg      = {bus.cfg_dir, bus.cfg_start, bus.cfg_len};
  assign bus.busy = ch_busy;
  assign cur_off  = ch_off[sel];
  assign accept   = (state == XFER) && bus.intrack && bus.hRDY && bus.holdack;

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    dma_chan_regs u_regs (
      .clk       (clk),
      .rst_n     (rst_n),
      .cfg_we    (bus.cfg_we && (bus.cfg_ch == 1'(g))),
      .cfg       (cfg),
      .beat      (ch_beat[g]),
      .clear     (ch_clear[g]),
      .busy      (ch_busy[g]),
      .dir       (ch_dir[g]),
      .offset    (ch_off[g]),
      .remaining (ch_rem[g])
    );
  end

`ifdef DMA_CHAN_RR_ARB_EN
  logic last_served;

  // Resets to 1 so channel 0 takes the first contested grant
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_served <= 1'b1;
    end else if ((state == IDLE) && (|ch_busy)) begin
      last_served <= grant;
    end
  end

  always_comb begin
    grant = (&ch_busy) ? ~last_served : ~ch_busy[0];
  end
`else
  always_comb begin
    grant = ~ch_busy[0];
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      sel           <= 1'b0;
      bus.rhr       <= 1'b0;
      bus.intrREQ   <= '0;
      bus.Addressin <= '0;
      bus.done      <= '0;
    end else begin
      state         <= state_nxt;
      sel           <= sel_nxt;
      bus.rhr       <= rhr_nxt;
      bus.intrREQ   <= req_nxt;
      bus.Addressin <= addr_nxt;
      bus.done      <= done_nxt;
    end
  end

  // Outputs are computed one edge ahead so that every port comes from a flop
  always_comb begin
    state_nxt = state;
    sel_nxt   = sel;
    rhr_nxt   = bus.rhr;
    req_nxt   = bus.intrREQ;
    addr_nxt  = bus.Addressin;
    done_nxt  = '0;
    ch_beat   = '0;
    ch_clear  = '0;

    case (state)
      IDLE: begin
        if (|ch_busy) begin
          sel_nxt   = grant;
          state_nxt = HOLD;
          rhr_nxt   = 1'b1;
          req_nxt   = {ch_dir[grant], 1'b0, grant};
        end
      end
      HOLD: begin
        if (bus.holdack) begin
          state_nxt = XFER;
          req_nxt   = {ch_dir[sel], 1'b1, sel};
          addr_nxt  = {sel, cur_off};
        end
      end
      XFER: begin
        if (!bus.holdack) begin
          // Bus taken back: keep requesting hold and resume at the same address
          state_nxt    = HOLD;
          req_nxt[VLD] = 1'b0;
        end else if (accept) begin
          ch_beat[sel] = 1'b1;
          if (ch_rem[sel] == LEN_W'(1)) begin
            state_nxt     = DONE;
            rhr_nxt       = 1'b0;
            req_nxt[VLD]  = 1'b0;
            done_nxt[sel] = 1'b1;
          end else begin
            addr_nxt = {sel, OFF_W'(cur_off + OFF_W'(1))};
          end
        end
      end
      DONE: begin
        ch_clear[sel] = 1'b1;
        state_nxt     = IDLE;
        req_nxt       = '0;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_dma_chan_ctrl.sv
// Self-checking bench for dma_chan_ctrl against a transfer-level address model.
module tb_dma_chan_ctrl;
  import dma_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rnd_hs = 1'b0;
  int   ntest = 0;
  int   nfail = 0;
  int   ndone [2] = '{0, 0};
  int   exp_done [2] = '{0, 0};
  logic [8:0] obs_q [$];
  logic [8:0] exp_q [$];

  dma_chan_ctrl_if bus ();

  dma_chan_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    ntest++;
    assert (got === want) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, want);
    end
  endtask

  // Beat monitor: a beat is taken on the edge following a negedge where all qualifiers are high
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.intrREQ[VLD] && bus.holdack && bus.hRDY && bus.intrack)
        obs_q.push_back({bus.intrREQ, bus.Addressin});
      if (bus.done != 2'b00) begin
        if (bus.done[0]) ndone[0]++;
        if (bus.done[1]) ndone[1]++;
        chk("rhr_low_in_done", 32'(bus.rhr), 32'd0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rnd_hs) begin
      bus.holdack = ($urandom_range(0, 7) != 0);
      bus.hRDY    = ($urandom_range(0, 5) != 0);
      bus.intrack = ($urandom_range(0, 5) != 0);
    end
  endtask

  task automatic hs_all(input logic v);
    rnd_hs      = 1'b0;
    bus.holdack = v;
    bus.hRDY    = v;
    bus.intrack = v;
  endtask

  task automatic cfg(input logic ch, input logic dir, input int start, input int len);
    bus.cfg_we    = 1'b1;
    bus.cfg_ch    = ch;
    bus.cfg_dir   = dir;
    bus.cfg_start = 5'(start);
    bus.cfg_len   = 6'(len);
    tick();
    bus.cfg_we    = 1'b0;
  endtask

  // Reference: words ch*32 + (start+k) mod 32 for k < min(len, 32)
  task automatic expect_xfer(input logic ch, input logic dir, input int start, input int len);
    int n;
    int a;
    n = (len > 32) ? 32 : len;
    for (int k = 0; k < n; k++) begin
      a = int'(ch) * 32 + (start + k) % 32;
      exp_q.push_back({dir, 1'b1, ch, 6'(a)});
    end
    exp_done[ch]++;
  endtask

  task automatic drain(input string tag);
    int budget;
    budget = 4000;
    while ((ndone[0] < exp_done[0] || ndone[1] < exp_done[1] || bus.busy != 2'b00) && budget > 0) begin
      tick();
      budget--;
    end
    chk({tag, "_finished"}, 32'(budget > 0), 32'd1);
    chk({tag, "_nbeats"}, 32'(obs_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
      chk({tag, "_beat"}, 32'(obs_q[i]), 32'(exp_q[i]));
    chk({tag, "_done0"}, 32'(ndone[0]), 32'(exp_done[0]));
    chk({tag, "_done1"}, 32'(ndone[1]), 32'(exp_done[1]));
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic wait_beats(input int n);
    int budget;
    budget = 200;
    while (obs_q.size() < n && budget > 0) begin
      tick();
      budget--;
    end
    chk("wait_beats", 32'(obs_q.size() >= n), 32'd1);
  endtask

  initial begin
    int s;
    int l;
    int s1;
    int l1;
    logic d;
    logic c;

    bus.cfg_we = 1'b0; bus.cfg_ch = 1'b0; bus.cfg_dir = 1'b0;
    bus.cfg_start = '0; bus.cfg_len = '0;
    hs_all(1'b1);

    // Reset values
    #12;
    chk("rst_rhr", 32'(bus.rhr), 32'd0);
    chk("rst_req", 32'(bus.intrREQ), 32'd0);
    chk("rst_addr", 32'(bus.Addressin), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick();

    // ch0 read, start 5, len 3; rhr two cycles after cfg_we
    cfg(1'b0, 1'b0, 5, 3);
    chk("lat_busy", 32'(bus.busy), 32'b01);
    chk("lat_rhr_c1", 32'(bus.rhr), 32'd0);
    tick();
    chk("lat_rhr_c2", 32'(bus.rhr), 32'd1);
    expect_xfer(1'b0, 1'b0, 5, 3);
    drain("ch0_basic");

    // ch1 write wrapping 30 -> 33 inside the upper region
    cfg(1'b1, 1'b1, 30, 4);
    expect_xfer(1'b1, 1'b1, 30, 4);
    drain("ch1_wrap");

    // holdack lost after two beats, resume at third address
    s = $urandom_range(0, 31);
    d = 1'($urandom_range(0, 1));
    cfg(1'b0, d, s, 4);
    expect_xfer(1'b0, d, s, 4);
    wait_beats(2);
    bus.holdack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("hold_vld", 32'(bus.intrREQ[VLD]), 32'd0);
      chk("hold_rhr", 32'(bus.rhr), 32'd1);
    end
    chk("hold_addr", 32'(bus.Addressin), 32'((s + 2) % 32));
    bus.holdack = 1'b1;
    drain("holdack_drop");

    // Back-to-back arming with random handshake: ch0 then ch1
    rnd_hs = 1'b1;
    s = $urandom_range(0, 31); l = $urandom_range(1, 32);
    s1 = $urandom_range(0, 31); l1 = $urandom_range(1, 32);
    cfg(1'b0, 1'b0, s, l);
    cfg(1'b1, 1'b1, s1, l1);
    chk("both_busy", 32'(bus.busy), 32'b11);
    expect_xfer(1'b0, 1'b0, s, l);
    expect_xfer(1'b1, 1'b1, s1, l1);
    drain("back_to_back");

    // Ignored writes: zero length, busy channel; oversize length clamps to 32
    s = $urandom_range(0, 31);
    cfg(1'b0, 1'b1, s, 0);
    chk("len0_ignored", 32'(bus.busy), 32'd0);
    s1 = $urandom_range(0, 31); l1 = $urandom_range(2, 32);
    cfg(1'b1, 1'b0, s1, l1);
    cfg(1'b1, 1'b1, 7, 9);
    cfg(1'b0, 1'b1, s, 50);
    chk("busy_after_ign", 32'(bus.busy), 32'b11);
    expect_xfer(1'b1, 1'b0, s1, l1);
    expect_xfer(1'b0, 1'b1, s, 50);
    drain("ignored_clamp");

    // Random single-channel transfers
    for (int it = 0; it < 6; it++) begin
      c = 1'($urandom_range(0, 1));
      d = 1'($urandom_range(0, 1));
      s = $urandom_range(0, 31);
      l = $urandom_range(0, 45);
      cfg(c, d, s, l);
      if (l != 0) expect_xfer(c, d, s, l);
      else chk("rand_len0", 32'(bus.busy), 32'd0);
      drain("random");
    end

    // cfg_we to the finishing channel during its DONE cycle is dropped
    hs_all(1'b1);
    s = $urandom_range(0, 31);
    cfg(1'b1, 1'b0, s, 1);
    expect_xfer(1'b1, 1'b0, s, 1);
    for (int i = 0; i < 20 && bus.done[1] !== 1'b1; i++) tick();
    chk("done_seen", 32'(bus.done), 32'b10);
    cfg(1'b1, 1'b1, 3, 5);
    chk("done_cfg_ign", 32'(bus.busy), 32'd0);
    tick();
    tick();
    chk("done_cfg_rhr", 32'(bus.rhr), 32'd0);
    drain("done_cycle_cfg");

    // Asynchronous reset mid-transfer
    cfg(1'b0, 1'b1, 0, 8);
    wait_beats(2);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_rhr", 32'(bus.rhr), 32'd0);
    chk("arst_req", 32'(bus.intrREQ), 32'd0);
    chk("arst_addr", 32'(bus.Addressin), 32'd0);
    chk("arst_busy", 32'(bus.busy), 32'd0);
    chk("arst_done", 32'(bus.done), 32'd0);
    obs_q.delete();
    tick();
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    chk("post_rst_busy", 32'(bus.busy), 32'd0);
    chk("post_rst_rhr", 32'(bus.rhr), 32'd0);
    chk("post_rst_beats", 32'(obs_q.size()), 32'd0);
    chk("post_rst_done0", 32'(ndone[0]), 32'(exp_done[0]));

    $display("[TB] %0d tests run, %0d failed", ntest, nfail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
